column_adc_readout: RTL
=======================

Name: column_adc_readout

Overview:
- Downstream consumer of the 8-bit Gray counter in the single-slope column ADC.
- Controls the counter's reset and, during a conversion window, latches the Gray code for each column on that column's comparator trip.
- After conversion, decodes each latched code to binary and streams the columns out one at a time over a valid/ready handshake to the image readout path.

Parameters:
WIDTH, 8, code width; must match the Gray counter WIDTH
COLUMNS, 4, number of comparator columns/latches
CONV_CYCLES, 255, conversion window length in clk cycles; legal range 1..2^WIDTH-1

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a conversion; honoured only in IDLE
gray_in  in  WIDTH  Gray-coded count from the counter output
cmp  in  COLUMNS  comparator outputs, synchronous to clk; bit c high = ramp has passed column c
counter_reset  out  1  registered; drives the Gray counter reset
busy  out  1  high in CONVERT and READOUT
data  out  WIDTH  binary (decoded) sample of column data_col
data_col  out  max(1,$clog2(COLUMNS))  column index of the current data word
data_valid  out  1  data/data_col valid
data_ready  in  1  downstream accepts the word when data_valid & data_ready
done  out  1  one-cycle pulse after the last column transfers

Behaviour:
- Reset is asynchronous and active-high.
  - While reset is asserted: state=IDLE; counter_reset=1; busy=0; data_valid=0; done=0; data=0; data_col=0.
  - All column latches and captured flags clear to 0.
  - Applies mid-conversion or mid-readout: the operation is aborted and no done pulse is generated.
- IDLE:
  - counter_reset=1.
  - start=1 at edge E0 → CONVERT. counter_reset=0 from E0, captured flags cleared at E0, cycle index k=0.
- CONVERT:
  - The counter outputs gray(k) during cycle k (k=0..CONV_CYCLES-1).
  - For each column c with captured[c]=0 and cmp[c]=1 in cycle k: latch mem[c]=gray_in and set captured[c] at the end of cycle k.
  - Later cmp activity on a captured column is ignored; cmp may fall again without effect.
  - Several columns may trip in the same cycle; all of them capture.
  - After cycle CONV_CYCLES-1:
    - Every uncaptured column is saturated to mem[c]=gray(2^WIDTH-1).
    - counter_reset returns to 1 and the block enters READOUT with column index 0.
- READOUT:
  - data_valid=1; data = Gray-to-binary decode of mem[data_col], so column c reads k or 2^WIDTH-1 if saturated.
  - data and data_col are held stable while data_valid & !data_ready; backpressure may last indefinitely.
  - On transfer, data_col increments.
  - On transfer of column COLUMNS-1: data_valid=0 next cycle, done=1 for exactly one cycle, busy=0, back to IDLE.
  - data_valid is never asserted outside READOUT.
- start is ignored while busy=1. start in the same cycle as done's assertion is ignored; a new conversion needs start while in IDLE.
- Decode is combinational from the selected latch; each output bit b = XOR of Gray bits b..WIDTH-1.

Optional Feature:
- Macro: COLUMN_ADC_OVF_FLAG_EN.
- When defined:
  - An extra output data_ovf (1 bit) is present, equal to ~captured[data_col] during READOUT and 0 otherwise.
  - It is 0 on reset.
  - It marks saturated (never-tripped) columns.
- When undefined: the port is absent; the saturated value 2^WIDTH-1 is the only indication.

Test Plan:
- Reset mid-CONVERT at k=40 → counter_reset=1, busy=0, data_valid=0 asynchronously; no done pulse; the next start converts normally.
- start; cmp[0] rises k=10, cmp[1] k=100, cmp[2] k=200, cmp[3] k=254; data_ready=1 → four words col0..3 = 10, 100, 200, 254 on consecutive cycles; then one-cycle done.
- start; no cmp activity → all four columns read 255; with COLUMN_ADC_OVF_FLAG_EN, data_ovf=1 on all four.
- cmp[1] and cmp[2] both rise at k=0, cmp[1] falls at k=5 and rises at k=50 → col1=0, col2=0; the re-trip is ignored.
- Readout with data_ready low for 7 cycles on col2 → data/data_col stable at col2 throughout; exactly four transfers total, no skipped or duplicated columns.
- start pulsed during CONVERT and during READOUT → ignored; busy stays high, results unaffected, single done.

Source files
------------

// File: rtl/column_adc_readout.sv
// column_adc_readout
// Readout controller for the single-slope column ADC. It holds the shared
// Gray counter in reset while idle and releases it for a conversion window.
// During the window each column latches the Gray code on its first
// comparator trip. Afterwards the columns are decoded to binary and streamed
// out one at a time over a valid/ready handshake.
//
// Parameters:
//   WIDTH        code width, must match the Gray counter
//   COLUMNS      number of comparator columns / latches
//   CONV_CYCLES  conversion window length in clk cycles (1 .. 2^WIDTH-1)
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   start          one-cycle conversion request, honoured only in IDLE
//   gray_in        Gray-coded count from the counter
//   cmp            per-column comparator outputs (synchronous to clk)
//   counter_reset  registered reset to the Gray counter
//   busy           high during CONVERT and READOUT
//   data           binary value of column data_col (0 when not valid)
//   data_col       column index of the current word
//   data_valid     data/data_col valid
//   data_ready     downstream accept
//   data_ovf       (COLUMN_ADC_OVF_FLAG_EN only) column never tripped
//   done           one-cycle pulse after the last column transfers
//
// Optional feature macro: COLUMN_ADC_OVF_FLAG_EN adds the data_ovf output.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | counter held in reset, waiting for start
// CONVERT | counter running, columns latch gray_in on first comparator trip
// READOUT | decoded columns streamed out over valid/ready

module column_adc_readout #(
  parameter int WIDTH       = 8,
  parameter int COLUMNS     = 4,
  parameter int CONV_CYCLES = 255,
  localparam int COL_W      = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   gray_in,
  input  logic [COLUMNS-1:0] cmp,
  output logic               counter_reset,
  output logic               busy,
  output logic [WIDTH-1:0]   data,
  output logic [COL_W-1:0]   data_col,
  output logic               data_valid,
  input  logic               data_ready,
`ifdef COLUMN_ADC_OVF_FLAG_EN
  output logic               data_ovf,
`endif
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    READOUT = 2'd2
  } state_t;

  // Gray code of the full-scale count 2^WIDTH-1 is a lone MSB.
  localparam logic [WIDTH-1:0] SAT_GRAY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] TMR_LOAD = WIDTH'(CONV_CYCLES - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);

  state_t             state;
  logic [WIDTH-1:0]   tmr;
  logic [COLUMNS-1:0] captured;
  logic [WIDTH-1:0]   mem [COLUMNS];
  logic [WIDTH-1:0]   sel_gray;
  logic [WIDTH-1:0]   sel_bin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      counter_reset <= 1'b1;
      busy          <= 1'b0;
      data_valid    <= 1'b0;
      done          <= 1'b0;
      data_col      <= '0;
      tmr           <= '0;
      captured      <= '0;
      for (int c = 0; c < COLUMNS; c++) mem[c] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // start coinciding with the done pulse is deliberately dropped
          if (start && !done) begin
            state         <= CONVERT;
            counter_reset <= 1'b0;
            busy          <= 1'b1;
            captured      <= '0;
            tmr           <= TMR_LOAD;
          end
        end
        CONVERT: begin
          for (int c = 0; c < COLUMNS; c++) begin
            if (!captured[c] && cmp[c]) begin
              mem[c]      <= gray_in;
              captured[c] <= 1'b1;
            end else if (tmr == '0 && !captured[c]) begin
              mem[c] <= SAT_GRAY;
            end
          end
          if (tmr == '0) begin
            state         <= READOUT;
            counter_reset <= 1'b1;
            data_valid    <= 1'b1;
            data_col      <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        READOUT: begin
          if (data_ready) begin
            if (data_col == LAST_COL) begin
              state      <= IDLE;
              data_valid <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
              data_col   <= '0;
            end else begin
              data_col <= data_col + 1'b1;
            end
          end
        end
        default: begin
          state         <= IDLE;
          counter_reset <= 1'b1;
          busy          <= 1'b0;
          data_valid    <= 1'b0;
        end
      endcase
    end
  end

  // Binary bit b is the XOR of Gray bits b..WIDTH-1.
  always_comb begin
    sel_gray = mem[data_col];
    sel_bin  = '0;
    for (int b = 0; b < WIDTH; b++) sel_bin[b] = ^(sel_gray >> b);
  end

  assign data = data_valid ? sel_bin : '0;

`ifdef COLUMN_ADC_OVF_FLAG_EN
  assign data_ovf = data_valid & ~captured[data_col];
`endif

endmodule
